mod47_cmul_arb: RTL and testbench



---
 rtl/mod47_pkg.sv | 14 +
 rtl/mod47_cmul77.sv | 17 +
 rtl/mod47_cmul_arb.sv | 115 +++++++++++
 tb/tb_mod47_cmul_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod47_pkg.sv
// Shared constants, types and helpers for the mod-47 residue arithmetic blocks.
package mod47_pkg;

    localparam int unsigned RES_W  = 6;
    localparam int unsigned MOD    = 47;
    localparam int unsigned CMUL_K = 77;

    typedef logic [RES_W-1:0] res_t;

    function automatic logic in_range(res_t x);
        return x < res_t'(MOD);
    endfunction

endpackage

// File: rtl/mod47_cmul77.sv
// Combinational constant multiplier: z = (x * 77) mod 47 on 6-bit residues.
module mod47_cmul77
    import mod47_pkg::*;
(
    input  res_t x,
    output res_t z
);

    // 77 mod 47 = 30, so the product never exceeds 63*30 and fits in 12 bits.
    localparam logic [11:0] KRED = 12'(CMUL_K % MOD);

    logic [11:0] prod;

    assign prod = 12'(x) * KRED;
    assign z    = res_t'(prod % 12'(MOD));

endmodule

// File: rtl/mod47_cmul_arb.sv
// Round-robin arbiter sharing one mod-47 constant multiplier among N_REQ requesters,
// with a one-deep tagged output register and a saturating range-error counter.
module mod47_cmul_arb
    import mod47_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ID_W      = $clog2(N_REQ),
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [RES_W*N_REQ-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RES_W-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_err,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    res_t                 out_data_q, out_data_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic                 out_err_q, out_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic            load_en;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic            transfer;
    res_t            sel_x;
    res_t            mul_z;
    logic            x_ok;

    assign load_en = !out_valid_q || out_ready;

    // Cyclic search for the first valid requester at or above rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            automatic int unsigned idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    // Gated by rst_n so no requester is ever accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && load_en && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = load_en && grant_any;
    assign sel_x    = req_data[32'(grant_idx)*RES_W +: RES_W];
    assign x_ok     = in_range(sel_x);

    mod47_cmul77 u_cmul (
        .x (sel_x),
        .z (mul_z)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = x_ok ? mul_z : '0;
            out_id_d    = grant_idx;
            out_err_d   = !x_ok;
            rr_ptr_d    = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
            if (!x_ok && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mod47_cmul_arb.sv
// Self-checking bench for mod47_cmul_arb: behavioural model compared every cycle,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_mod47_cmul_arb;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [6*N-1:0] req_data;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_data;
    logic [1:0]    out_id;
    logic          out_err;
    logic [7:0]    err_cnt;

    int errors = 0;
    int checks = 0;

    mod47_cmul_arb #(
        .N_REQ     (N),
        .ID_W      (2),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid, m_data, m_id, m_err, m_cnt, m_ptr;
    int m_g;
    int m_x;

    // Lowest valid index >= ptr, otherwise lowest valid index overall, otherwise none.
    function automatic int model_grant(int ptr, logic [N-1:0] v);
        for (int i = ptr; i < N; i++) if (v[i]) return i;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    assign m_g = (rst_n && (m_valid == 0 || out_ready)) ? model_grant(m_ptr, req_valid) : -1;

    always_comb begin
        m_x = 0;
        if (m_g >= 0) m_x = int'(req_data[m_g*6 +: 6]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_data <= 0; m_id <= 0; m_err <= 0; m_cnt <= 0; m_ptr <= 0;
        end else if (m_g >= 0) begin
            m_valid <= 1;
            m_id    <= m_g;
            m_ptr   <= (m_g + 1) % N;
            m_err   <= (m_x >= 47) ? 1 : 0;
            m_data  <= (m_x >= 47) ? 0 : (m_x * 77) % 47;
            if (m_x >= 47 && m_cnt < 255) m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_valid <= 0;
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        chk("req_ready", int'(req_ready), (m_g >= 0) ? (1 << m_g) : 0);
        chk("out_valid", int'(out_valid), m_valid);
        chk("err_cnt", int'(err_cnt), m_cnt);
        if (m_valid != 0) begin
            chk("out_data", int'(out_data), m_data);
            chk("out_id", int'(out_id), m_id);
            chk("out_err", int'(out_err), m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int x);
        int n;
        tick();
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_data[r*6 +: 6] = 6'(x);
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept_in_time", int'(n < 20), 1);
        tick();
        req_valid = '0;
    endtask

    task automatic pulse_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int order_a[5] = '{0, 1, 2, 3, 0};
    int order_b[4] = '{2, 3, 0, 2};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] acc;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_id", int'(out_id), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        tick();
        rst_n = 1'b1;

        // Single requester 0, x=1.
        tick();
        req_valid = 4'b0001;
        req_data[5:0] = 6'd1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_ready", int'(req_ready), 1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_out_data", int'(out_data), 30);
        chk("t1_out_id", int'(out_id), 0);
        chk("t1_out_err", int'(out_err), 0);

        // Operand sweep on requester 2.
        for (int x = 0; x <= 47; x++) begin
            send(2, x);
            @(negedge clk);
            chk("sweep_id", int'(out_id), 2);
            if (x == 0)  chk("sweep_x0", int'(out_data), 0);
            if (x == 2)  chk("sweep_x2", int'(out_data), 13);
            if (x == 46) chk("sweep_x46", int'(out_data), 17);
            if (x == 47) begin
                chk("sweep_x47_err", int'(out_err), 1);
                chk("sweep_x47_data", int'(out_data), 0);
                chk("sweep_x47_cnt", int'(err_cnt), 1);
            end
        end

        // Fairness from a fresh rr_ptr.
        pulse_reset();
        tick();
        for (int i = 0; i < N; i++) req_data[i*6 +: 6] = 6'($urandom_range(0, 46));
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fair_all", int'(req_ready), 1 << order_a[k]);
            tick();
        end
        req_valid = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fair_skip1", int'(req_ready), 1 << order_b[k]);
            tick();
        end

        // Backpressure with result from requester 2 held.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready_zero", int'(req_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_id", int'(out_id), 2);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", int'(req_ready), 8);
        tick();

        // Saturation of the error counter.
        req_valid = 4'b0001;
        req_data[5:0] = 6'd63;
        repeat (300) tick();
        @(negedge clk);
        chk("sat_err_cnt", int'(err_cnt), 255);

        // Reset mid-stream with a result held.
        tick();
        chk("mid_pre_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_out_data", int'(out_data), 0);
        chk("mid_out_id", int'(out_id), 0);
        chk("mid_out_err", int'(out_err), 0);
        chk("mid_err_cnt", int'(err_cnt), 0);
        chk("mid_req_ready", int'(req_ready), 0);
        tick();
        req_valid = 4'b0110;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_first_grant", int'(req_ready), 2);

        // Random traffic; requesters hold valid/data until accepted.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[i*6 +: 6] = ($urandom_range(0, 9) == 0) ?
                        6'($urandom_range(47, 63)) : 6'($urandom_range(0, 46));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
